// File: rtl/ysyx_23060124__ifu_fetch_pkg.sv
// Shared IFU fetch definitions: reset PC, FSM states and queue entry layout.
package ysyx_23060124__ifu_fetch_pkg;

    localparam int unsigned IFU_ADDR_WIDTH = 32;
    localparam int unsigned IFU_DATA_WIDTH = 32;

    localparam logic [IFU_ADDR_WIDTH-1:0] IFU_RESET_PC = 32'h3000_0000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [IFU_ADDR_WIDTH-1:0] pc;
        logic [IFU_DATA_WIDTH-1:0] inst;
    } q_entry_t;

endpackage

// File: rtl/ysyx_23060124__ifu_fetch_q.sv
// Two-entry fetch FIFO; entry 0 is always the head. Flush beats a same-cycle push.
module ysyx_23060124__ifu_fetch_q
    import ysyx_23060124__ifu_fetch_pkg::*;
#(
    parameter int unsigned W = $bits(q_entry_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    localparam int unsigned CW = 2;

    logic [CW-1:0] count_q, count_d, base_c;
    logic [W-1:0]  ent0_q, ent0_d;
    logic [W-1:0]  ent1_q, ent1_d;
    logic          pop_ok_c, push_ok_c;

    // Next-state: pop shifts entry 1 forward, push lands in the first free slot.
    always_comb begin
        count_d   = count_q;
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        pop_ok_c  = pop_i && (count_q != CW'(0));
        push_ok_c = push_i && ((count_q != CW'(2)) || pop_ok_c);
        base_c    = count_q - CW'(pop_ok_c);
        if (flush_i) begin
            count_d = CW'(0);
        end else begin
            if (pop_ok_c) begin
                ent0_d = ent1_q;
            end
            if (push_ok_c) begin
                if (base_c == CW'(0)) begin
                    ent0_d = push_data_i;
                end else begin
                    ent1_d = push_data_i;
                end
            end
            count_d = base_c + CW'(push_ok_c);
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            ent0_q  <= '0;
            ent1_q  <= '0;
        end else begin
            count_q <= count_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = ent0_q;

endmodule

// File: rtl/ysyx_23060124__ifu_fetch.sv
// IFU fetch front end: PC ownership, icache request/response, redirect kill and fence.i sequencing.
module ysyx_23060124__ifu_fetch
    import ysyx_23060124__ifu_fetch_pkg::*;
#(
    parameter int unsigned               ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned               DATA_WIDTH = IFU_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n_sync,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  fence_i_in,
    output logic                  icache_req,
    output logic [ADDR_WIDTH-1:0] icache_addr,
    input  logic [DATA_WIDTH-1:0] icache_data,
    input  logic                  icache_valid,
    output logic                  icache_fence_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst
);

    localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic                  kill_q, kill_d;
    logic                  fence_pend_q, fence_pend_d;
    logic                  can_issue_c;
    logic                  push_c;
    logic [1:0]            q_count;
    logic [EW-1:0]         q_head;

    // Request never depends on icache_valid: the hit path is combinational from req.
    assign can_issue_c    = ((q_count != 2'd2) || out_ready) && !redirect_valid && !fence_pend_q;
    assign icache_req     = rst_n_sync && (state_q == S_FETCH) && can_issue_c;
    assign icache_addr    = pc_q;
    assign icache_fence_i = fence_pend_q && (state_q == S_FETCH);

    // Next-state, PC update and queue push decision.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        kill_d       = kill_q;
        fence_pend_d = fence_pend_q;
        push_c       = 1'b0;
        if (icache_fence_i) begin
            fence_pend_d = 1'b0;
        end
        if (fence_i_in) begin
            fence_pend_d = 1'b1;
        end
        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (icache_req) begin
                    if (icache_valid) begin
                        push_c = 1'b1;
                        pc_d   = pc_q + ADDR_WIDTH'(4);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (icache_valid) begin
                    state_d = S_FETCH;
                    kill_d  = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (kill_q) begin
                        pc_d = tgt_q;
                    end else begin
                        push_c = 1'b1;
                        pc_d   = pc_q + ADDR_WIDTH'(4);
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                    tgt_d  = redirect_pc;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            kill_q       <= 1'b0;
            fence_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            kill_q       <= kill_d;
            fence_pend_q <= fence_pend_d;
        end
    end

    ysyx_23060124__ifu_fetch_q #(
        .W (EW)
    ) u_q (
        .clk         (clk),
        .rst_n       (rst_n_sync),
        .push_i      (push_c),
        .push_data_i ({pc_q, icache_data}),
        .pop_i       (out_ready),
        .flush_i     (redirect_valid),
        .count_o     (q_count),
        .head_o      (q_head)
    );

    assign out_valid = (q_count != 2'd0);
    assign out_pc    = q_head[EW-1:DATA_WIDTH];
    assign out_inst  = q_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ysyx_23060124__ifu_fetch.sv
// Bench for the IFU fetch front end: vector table, directed corner sequences, random run vs stream model.
module tb_ysyx_23060124__ifu_fetch;

    localparam logic [31:0] RPC = 32'h3000_0000;

    logic        clk;
    logic        rst_n_sync;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fence_i_in;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_valid;
    logic        icache_fence_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic        hit_en, man_resp, force_en, rand_mode;
    logic [31:0] force_data;
    logic        rpend, miss_resp;
    logic [1:0]  rcnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Stream model state for the random run.
    logic [31:0] exp_pc, pend_addr;
    logic        pending, owed;
    int          accepts;

    typedef struct {
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t tbl [10];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        mem_word = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    ysyx_23060124__ifu_fetch dut (
        .clk            (clk),
        .rst_n_sync     (rst_n_sync),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fence_i_in     (fence_i_in),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_data    (icache_data),
        .icache_valid   (icache_valid),
        .icache_fence_i (icache_fence_i),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Icache model: combinational hit, manual response, or random-latency miss.
    assign miss_resp    = rand_mode && rpend && (rcnt == 2'd0);
    assign icache_valid = (hit_en && icache_req) || miss_resp || man_resp;
    assign icache_data  = force_en ? force_data : mem_word(icache_addr);

    always @(posedge clk) begin
        if (!rand_mode || !rst_n_sync) begin
            rpend <= 1'b0;
        end else if (rpend) begin
            if (rcnt == 2'd0) rpend <= 1'b0;
            else              rcnt  <= rcnt - 2'd1;
        end else if (icache_req && !icache_valid) begin
            rpend <= 1'b1;
            rcnt  <= 2'($urandom_range(0, 3));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_sync     = 1'b0;
        redirect_valid = 1'b0;
        fence_i_in     = 1'b0;
        man_resp       = 1'b0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_req",   32'(icache_req), 32'd0);
        chk("rst_addr",  icache_addr, RPC);
        chk("rst_fence", 32'(icache_fence_i), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc",    out_pc, 32'd0);
        chk("rst_inst",  out_inst, 32'd0);
        cyc();
        rst_n_sync = 1'b1;
    endtask

    // One cycle of the fetch-stream reference: in-order PCs, restarted by every redirect.
    task automatic model_step();
        if (pending) begin
            chk("no_req_in_wait", 32'(icache_req), 32'd0);
            chk("addr_stable", icache_addr, pend_addr);
        end
        if (icache_fence_i) begin
            chk("fence_no_pending", 32'(pending), 32'd0);
            chk("fence_requested", 32'(owed), 32'd1);
            chk("fence_no_req", 32'(icache_req), 32'd0);
            owed = 1'b0;
        end
        if (out_valid && out_ready) begin
            chk("rand_pc", out_pc, exp_pc);
            chk("rand_inst", out_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            accepts++;
        end
        if (redirect_valid) begin
            exp_pc = redirect_pc;
            if (fence_i_in) owed = 1'b1;
        end
        if (pending) begin
            if (icache_valid) pending = 1'b0;
        end else if (icache_req && !icache_valid) begin
            pending   = 1'b1;
            pend_addr = icache_addr;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        int w;

        rst_n_sync     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fence_i_in     = 1'b0;
        out_ready      = 1'b1;
        hit_en         = 1'b0;
        man_resp       = 1'b0;
        force_en       = 1'b0;
        force_data     = 32'd0;
        rand_mode      = 1'b0;

        // Hits with backpressure, then full-queue push+pop, then release.
        tbl[0] = '{1'b0, 1'b1, 32'h3000_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h3000_0004, 1'b1, 32'h3000_0000};
        tbl[2] = '{1'b0, 1'b0, 32'h3000_0008, 1'b1, 32'h3000_0000};
        tbl[3] = '{1'b0, 1'b0, 32'h3000_0008, 1'b1, 32'h3000_0000};
        tbl[4] = '{1'b1, 1'b1, 32'h3000_0008, 1'b1, 32'h3000_0000};
        tbl[5] = '{1'b1, 1'b1, 32'h3000_000C, 1'b1, 32'h3000_0004};
        tbl[6] = '{1'b1, 1'b1, 32'h3000_0010, 1'b1, 32'h3000_0008};
        tbl[7] = '{1'b0, 1'b0, 32'h3000_0014, 1'b1, 32'h3000_000C};
        tbl[8] = '{1'b1, 1'b1, 32'h3000_0014, 1'b1, 32'h3000_000C};
        tbl[9] = '{1'b1, 1'b1, 32'h3000_0018, 1'b1, 32'h3000_0010};

        hit_en = 1'b1;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            out_ready = tbl[i].ready;
            smp();
            chk($sformatf("vec%0d_req", i),   32'(icache_req), 32'(tbl[i].exp_req));
            chk($sformatf("vec%0d_addr", i),  icache_addr, tbl[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i),   out_pc, tbl[i].exp_pc);
                chk($sformatf("vec%0d_inst", i), out_inst, mem_word(tbl[i].exp_pc));
            end
            cyc();
        end

        // Miss then hit on the next line.
        hit_en    = 1'b0;
        out_ready = 1'b1;
        apply_reset();
        smp();
        chk("miss_req0", 32'(icache_req), 32'd1);
        chk("miss_addr0", icache_addr, RPC);
        cyc();
        for (int k = 1; k < 5; k++) begin
            smp();
            chk($sformatf("miss_wait%0d_req", k), 32'(icache_req), 32'd0);
            chk($sformatf("miss_wait%0d_addr", k), icache_addr, RPC);
            cyc();
        end
        force_en   = 1'b1;
        force_data = 32'h0000_0013;
        man_resp   = 1'b1;
        smp();
        chk("miss_resp_valid", 32'(out_valid), 32'd0);
        cyc();
        man_resp = 1'b0;
        force_en = 1'b0;
        smp();
        chk("miss_out_valid", 32'(out_valid), 32'd1);
        chk("miss_out_inst", out_inst, 32'h0000_0013);
        chk("miss_out_pc", out_pc, RPC);
        chk("miss_next_req", 32'(icache_req), 32'd1);
        chk("miss_next_addr", icache_addr, 32'h3000_0004);
        cyc();

        // Redirect two cycles into the miss on 3000_0004.
        smp(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        smp();
        chk("rdw_req", 32'(icache_req), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk("rdw_valid_a", 32'(out_valid), 32'd0);
        cyc();
        man_resp = 1'b1;
        smp();
        chk("rdw_valid_b", 32'(out_valid), 32'd0);
        cyc();
        man_resp = 1'b0;
        smp();
        chk("rdw_dropped", 32'(out_valid), 32'd0);
        chk("rdw_req_new", 32'(icache_req), 32'd1);
        chk("rdw_addr_new", icache_addr, 32'h8000_0100);
        cyc();

        // fence.i plus redirect during the miss on 8000_0100.
        pulses         = 0;
        redirect_valid = 1'b1;
        fence_i_in     = 1'b1;
        redirect_pc    = 32'h3000_0020;
        smp();
        pulses += int'(icache_fence_i);
        cyc();
        redirect_valid = 1'b0;
        fence_i_in     = 1'b0;
        smp();
        pulses += int'(icache_fence_i);
        chk("fnc_hold_a", 32'(icache_fence_i), 32'd0);
        cyc();
        man_resp = 1'b1;
        smp();
        pulses += int'(icache_fence_i);
        chk("fnc_hold_b", 32'(icache_fence_i), 32'd0);
        cyc();
        man_resp = 1'b0;
        smp();
        pulses += int'(icache_fence_i);
        chk("fnc_pulse", 32'(icache_fence_i), 32'd1);
        chk("fnc_pulse_noreq", 32'(icache_req), 32'd0);
        cyc();
        hit_en = 1'b1;
        smp();
        pulses += int'(icache_fence_i);
        chk("fnc_after_req", 32'(icache_req), 32'd1);
        chk("fnc_after_addr", icache_addr, 32'h3000_0020);
        cyc();
        smp();
        pulses += int'(icache_fence_i);
        chk("fnc_out_pc", out_pc, 32'h3000_0020);
        chk("fnc_pulse_count", 32'(pulses), 32'd1);
        cyc();

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        smp();
        chk("wrap_redirect_req", 32'(icache_req), 32'd0);
        cyc();
        redirect_valid = 1'b0;
        smp();
        chk("wrap_req_addr", icache_addr, 32'hFFFF_FFFC);
        cyc();
        smp();
        chk("wrap_next_addr", icache_addr, 32'h0000_0000);
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
        chk("wrap_out_inst", out_inst, mem_word(32'hFFFF_FFFC));
        cyc();

        // Reset in the middle of a miss; the late response must be ignored.
        hit_en = 1'b0;
        smp(); cyc();
        rst_n_sync = 1'b0;
        man_resp   = 1'b1;
        smp();
        chk("rmm_req", 32'(icache_req), 32'd0);
        chk("rmm_valid", 32'(out_valid), 32'd0);
        chk("rmm_addr", icache_addr, RPC);
        cyc();
        man_resp   = 1'b0;
        rst_n_sync = 1'b1;
        smp();
        chk("rmm_after_valid", 32'(out_valid), 32'd0);
        chk("rmm_after_req", 32'(icache_req), 32'd1);
        chk("rmm_after_addr", icache_addr, RPC);
        cyc();

        // Random run against the fetch-stream model.
        rand_mode = 1'b1;
        apply_reset();
        exp_pc  = RPC;
        pending = 1'b0;
        owed    = 1'b0;
        accepts = 0;
        for (int i = 0; i < 4000; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
            fence_i_in     = redirect_valid && ($urandom_range(0, 3) == 0);
            hit_en         = 1'($urandom_range(0, 1));
            smp();
            model_step();
            cyc();
        end
        redirect_valid = 1'b0;
        fence_i_in     = 1'b0;
        out_ready      = 1'b1;
        w = 0;
        while (owed && w < 40) begin
            smp();
            model_step();
            cyc();
            w++;
        end
        chk("rand_fence_drained", 32'(owed), 32'd0);
        chk("rand_progress", 32'(accepts > 500), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060124__ifu_fetch.md
# ysyx_23060124__ifu_fetch

Instruction-fetch front end of the IFU. Owns the PC and issues single-word fetch requests to the instruction cache. Buffers returned instructions in a 2-entry queue and presents them to the IDU over a valid/ready handshake. Handles branch redirects, including a redirect that arrives during an outstanding cache miss, and sequences `fence.i` invalidation so it never collides with a refill.

## Interface
Parameters:
- `RESET_PC`, default 32'h3000_0000: PC loaded at reset.
- `ADDR_WIDTH`, default 32: PC / address width.
- `DATA_WIDTH`, default 32: instruction width.

Ports:
- `clk`  in  1  sole clock.
- `rst_n_sync`  in  1  reset, asynchronous assert, active-low.
- `redirect_valid`  in  1  branch/jump/trap redirect; one-cycle pulse.
- `redirect_pc`  in  ADDR_WIDTH  redirect target, valid with `redirect_valid`.
- `fence_i_in`  in  1  one-cycle request to invalidate the icache; always accompanied by `redirect_valid`.
- `icache_req`  out  1  one-cycle fetch request.
- `icache_addr`  out  ADDR_WIDTH  fetch address; held stable from req until `icache_valid`.
- `icache_data`  in  DATA_WIDTH  instruction word.
- `icache_valid`  in  1  response strobe. Combinational with `icache_req` on a hit; later on a miss.
- `icache_fence_i`  out  1  one-cycle icache invalidate.
- `out_valid`  out  1  instruction available to IDU.
- `out_ready`  in  1  IDU accepts.
- `out_pc`  out  ADDR_WIDTH  PC of presented instruction.
- `out_inst`  out  DATA_WIDTH  presented instruction.

## Operation
- **State machine.** FETCH, WAIT.
- **Registers.**
  - `pc`
  - `kill` (drop the pending response)
  - `tgt` (latched redirect target)
  - `fence_pend`
  - queue of {pc, inst}: 2 entries, with `count` ∈ {0, 1, 2}
- **Issue condition.** `can_issue = (count<2 || out_ready) && !redirect_valid && !fence_pend`.
  - `icache_req = (state==FETCH) && can_issue`.
  - `icache_addr = pc` at all times.
- **FETCH.**
  - If req is issued and `icache_valid` is high the same cycle (hit): push {pc, icache_data}, `pc<=pc+4`, stay in FETCH.
  - If req is issued and `icache_valid` is low: go to WAIT.
- **WAIT.**
  - `icache_req` is held 0.
  - On `icache_valid`:
    - `kill==1`: discard the data, `pc<=tgt`, clear `kill`.
    - `kill==0`: push the word, `pc<=pc+4`.
  - In both cases go to FETCH.
- **Redirect in FETCH.** Req is suppressed that cycle. `pc<=redirect_pc`, queue flushed (`count<=0`).
- **Redirect in WAIT.** `kill<=1`, `tgt<=redirect_pc`, queue flushed. A later redirect in the same WAIT overwrites `tgt`.
- **Redirect and icache response in the same WAIT cycle.** The response is discarded and `pc<=redirect_pc`.
- **fence.i.** `fence_i_in` sets `fence_pend`.
  - `icache_fence_i` pulses for one cycle when `fence_pend` is set, the state is FETCH, and no response is pending; `fence_pend` clears at that point.
  - Issue resumes the cycle after the pulse.
  - A `fence_i_in` arriving in WAIT therefore takes effect only after the refill completes.
- **Queue.**
  - Push and pop may happen in the same cycle at any count, including 2.
  - A flush on the same cycle as a push discards that push.
  - `out_valid = count!=0`. `out_pc`/`out_inst` come from the head entry.
- **PC arithmetic.** Modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- **Reset values.**
  - Outputs: `icache_req=0`, `icache_addr=RESET_PC`, `icache_fence_i=0`, `out_valid=0`, `out_pc=0`, `out_inst=0`.
  - Internal: state=FETCH, `count=0`, `kill=0`, `fence_pend=0`.
- **Reset mid-miss.** Reset mid-miss returns to the reset state immediately. A response arriving after reset is ignored, because `icache_valid` is only acted upon in WAIT, or in FETCH with req issued.
- **Hit latency.** Req in cycle t gives `out_valid` in cycle t+1. Sustained throughput is 1 instruction/cycle while IDU accepts.
- **Miss latency.** Response in cycle t gives `out_valid` in t+1. The next req is issued in t+1.
- **Combinational-loop rule.** No combinational path from `icache_valid` to `icache_req`, because the icache hit is combinational from req.
- **Redirect.** First req to the new target is issued the cycle after the redirect, or the cycle after the killed response arrives.

## Structure
- Shared IFU package holds:
  - `RESET_PC`
  - state enum {FETCH, WAIT}
  - queue entry struct {pc, inst}
- One sub-module: `ysyx_23060124__ifu_fetch_q`, a 2-entry FIFO with push, pop and flush.

## Test plan
- **Back-to-back hits.**
  - Stimulus: icache always hits, `out_ready=1`, start from reset.
  - Response: `out_pc` = 3000_0000, 3000_0004, 3000_0008 on consecutive cycles starting at cycle 2.
- **Miss then hit.**
  - Stimulus: `icache_valid` 5 cycles after the req to 3000_0000, with data 0x00000013.
  - Response: `icache_req` low during the wait, `icache_addr` stable; `out_inst=0x13` one cycle after valid; next req is to 3000_0004.
- **Backpressure.**
  - Stimulus: `out_ready=0` with hits.
  - Response: exactly 2 requests issued, then `icache_req=0` until `out_ready=1`; no entry lost or duplicated.
- **Redirect during miss.**
  - Stimulus: `redirect_pc=8000_0100` 2 cycles into a miss.
  - Response: that response is dropped, no `out_valid`; next req address is 8000_0100.
- **fence.i during miss.**
  - Stimulus: `fence_i_in` plus redirect to 3000_0020 mid-miss.
  - Response: `icache_fence_i` pulses exactly once, after the response arrives; next req is to 3000_0020 the following cycle.
- **Full-queue simultaneous events.**
  - Stimulus: `count=2`, with push and pop in the same cycle.
  - Response: count stays 2 and order is preserved.
